code_lock_seq: RTL and testbench

- Parametrised sequential combination lock. The user sets two hex digits on A/B and presses enter once per step. After NUM_STEPS entries the block checks the whole sequence against CODE.
- On a correct sequence it asserts unlocked. Repeated failures trip a timed lockout.
- Drives active-low seven-segment displays for operand digits, step index, fail count and state glyph. Sits directly on board switches, a debounced button and the HEX displays.

---
 rtl/code_lock_seq.sv | 178 +++++++++++++++++
 tb/tb_code_lock_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_seq.sv
`timescale 1ns/1ps
// code_lock_seq: sequential two-digit combination lock with failure lockout
// and active-low seven-segment status displays.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_ENTRY   | collecting digit pairs, one per enter press
// S_VERDICT | single cycle: judge the accumulated mismatch flag
// S_OPEN    | correct code seen, unlocked high until the next press
// S_LOCKOUT | too many failed attempts, presses ignored until timer ends
module code_lock_seq #(
   parameter int unsigned              NUM_STEPS      = 3,
   parameter logic [8*NUM_STEPS-1:0]   CODE           = 24'h281996,
   parameter int unsigned              MAX_FAILS      = 3,
   parameter int unsigned              LOCKOUT_CYCLES = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       enter,
   output logic       unlocked,
   output logic       locked_out,
   output logic [3:0] step,
   output logic [6:0] H1,
   output logic [6:0] H2,
   output logic [6:0] H3,
   output logic [6:0] H4,
   output logic [6:0] H5
);

   localparam int unsigned TW          = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [3:0]  LAST_STEP    = 4'(NUM_STEPS - 1);
   localparam logic [3:0]  FAIL_LAST    = 4'(MAX_FAILS - 1);
   localparam logic [3:0]  FAIL_MAX     = 4'(MAX_FAILS);

   typedef enum logic [1:0] {
      S_ENTRY   = 2'd0,
      S_VERDICT = 2'd1,
      S_OPEN    = 2'd2,
      S_LOCKOUT = 2'd3
   } state_t;

   state_t        r_state;
   logic [3:0]    r_step;
   logic [3:0]    r_fail_cnt;
   logic          r_mismatch;
   logic          r_enter_q;
   logic [TW-1:0] r_timer;
   logic          r_unlocked;
   logic          r_locked_out;

   logic          w_press;
   logic [7:0]    w_code_byte;
   logic          w_neq;
   logic [6:0]    w_glyph;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h67;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign w_press = enter & ~r_enter_q;
   assign w_neq   = ({A, B} != w_code_byte);

   // select the expected pair for the current step; step 0 lives in the top byte
   always_comb begin
      w_code_byte = 8'h00;
      for (int unsigned i = 0; i < NUM_STEPS; i++) begin
         if (r_step == 4'(i)) begin
            w_code_byte = CODE[8*(NUM_STEPS-1-i) +: 8];
         end
      end
   end

   // lock sequencer; unlocked/locked_out are set on the same edge as the state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= S_ENTRY;
         r_step       <= 4'd0;
         r_fail_cnt   <= 4'd0;
         r_mismatch   <= 1'b0;
         r_enter_q    <= 1'b0;
         r_timer      <= '0;
         r_unlocked   <= 1'b0;
         r_locked_out <= 1'b0;
      end else begin
         r_enter_q <= enter;
         case (r_state)
            S_ENTRY: begin
               if (w_press) begin
                  r_mismatch <= r_mismatch | w_neq;
                  r_step     <= r_step + 4'd1;
                  if (r_step == LAST_STEP) begin
                     r_state <= S_VERDICT;
                  end
               end
            end
            S_VERDICT: begin
               r_step     <= 4'd0;
               r_mismatch <= 1'b0;
               if (!r_mismatch) begin
                  r_state    <= S_OPEN;
                  r_fail_cnt <= 4'd0;
                  r_unlocked <= 1'b1;
               end else if (r_fail_cnt == FAIL_LAST) begin
                  r_state      <= S_LOCKOUT;
                  r_timer      <= TIMER_LOAD;
                  r_fail_cnt   <= r_fail_cnt + 4'd1;
                  r_locked_out <= 1'b1;
               end else begin
                  r_state <= S_ENTRY;
                  if (r_fail_cnt < FAIL_MAX) begin
                     r_fail_cnt <= r_fail_cnt + 4'd1;
                  end
               end
            end
            S_OPEN: begin
               if (w_press) begin
                  r_state    <= S_ENTRY;
                  r_unlocked <= 1'b0;
               end
            end
            S_LOCKOUT: begin
               if (r_timer == '0) begin
                  r_state      <= S_ENTRY;
                  r_fail_cnt   <= 4'd0;
                  r_locked_out <= 1'b0;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            default: r_state <= S_ENTRY;
         endcase
      end
   end

   // state glyph for the status display
   always_comb begin
      w_glyph = 7'h79;
      case (r_state)
         S_ENTRY:   w_glyph = 7'h79;
         S_VERDICT: w_glyph = 7'h39;
         S_OPEN:    w_glyph = 7'h3F;
         S_LOCKOUT: w_glyph = 7'h38;
         default:   w_glyph = 7'h79;
      endcase
   end

   assign unlocked   = r_unlocked;
   assign locked_out = r_locked_out;
   assign step       = r_step;
   assign H1         = ~seg7(A);
   assign H2         = ~seg7(B);
   assign H3         = ~seg7(r_step);
   assign H4         = ~seg7(r_fail_cnt);
   assign H5         = ~w_glyph;

endmodule

// File: tb/tb_code_lock_seq.sv
`timescale 1ns/1ps
// Bench for code_lock_seq: directed stimulus pushes cycle-stamped expected
// output snapshots; a negedge monitor pops and compares them.
module tb_code_lock_seq;

   localparam logic [6:0] G_E = 7'h79;
   localparam logic [6:0] G_C = 7'h39;
   localparam logic [6:0] G_O = 7'h3F;
   localparam logic [6:0] G_L = 7'h38;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] A = 4'h0, B = 4'h0, A2 = 4'h0, B2 = 4'h0;
   logic       enter = 1'b0, enter2 = 1'b0;

   logic       ul0, lo0, ul1, lo1;
   logic [3:0] st0, st1;
   logic [6:0] h1_0, h2_0, h3_0, h4_0, h5_0;
   logic [6:0] h1_1, h2_1, h3_1, h4_1, h5_1;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      int          cyc;
      int          dut;
      bit          chk_ab;
      logic [26:0] v;
      logic [13:0] ab;
      string       nm;
   } exp_t;

   exp_t q[$];

   code_lock_seq #(.NUM_STEPS(3), .CODE(24'h281996), .MAX_FAILS(3), .LOCKOUT_CYCLES(10)) u_dut0 (
      .clock(clock), .reset(reset), .A(A), .B(B), .enter(enter),
      .unlocked(ul0), .locked_out(lo0), .step(st0),
      .H1(h1_0), .H2(h2_0), .H3(h3_0), .H4(h4_0), .H5(h5_0)
   );

   code_lock_seq #(.NUM_STEPS(1), .CODE(8'hA5), .MAX_FAILS(3), .LOCKOUT_CYCLES(10)) u_dut1 (
      .clock(clock), .reset(reset), .A(A2), .B(B2), .enter(enter2),
      .unlocked(ul1), .locked_out(lo1), .step(st1),
      .H1(h1_1), .H2(h2_1), .H3(h3_1), .H4(h4_1), .H5(h5_1)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [6:0] tseg(input logic [3:0] d);
      case (d)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h67;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   task automatic exp_at(input int off, input int d, input string nm, input logic ul,
                         input logic lo, input logic [3:0] st, input logic [3:0] fc,
                         input logic [6:0] g);
      exp_t e;
      e.cyc    = cyc + off;
      e.dut    = d;
      e.chk_ab = 1'b0;
      e.ab     = '0;
      e.nm     = nm;
      e.v      = {ul, lo, st, ~tseg(st), ~tseg(fc), ~g};
      q.push_back(e);
   endtask

   task automatic exp_ab(input string nm, input logic [3:0] a, input logic [3:0] b);
      exp_t e;
      e.cyc    = cyc;
      e.dut    = 0;
      e.chk_ab = 1'b1;
      e.ab     = {~tseg(a), ~tseg(b)};
      e.nm     = nm;
      e.v      = {1'b0, 1'b0, 4'd0, ~tseg(4'd0), ~tseg(4'd0), ~G_E};
      q.push_back(e);
   endtask

   // monitor: compare every snapshot due in this cycle, flag any left behind
   always @(negedge clock) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc <= cyc) begin
            logic [26:0] av;
            logic [13:0] aab;
            av  = (q[i].dut == 0) ? {ul0, lo0, st0, h3_0, h4_0, h5_0}
                                  : {ul1, lo1, st1, h3_1, h4_1, h5_1};
            aab = (q[i].dut == 0) ? {h1_0, h2_0} : {h1_1, h2_1};
            checks = checks + 1;
            if (q[i].cyc < cyc) begin
               failures = failures + 1;
               $display("FAIL %s missed: due cyc=%0d now=%0d", q[i].nm, q[i].cyc, cyc);
            end else if (av !== q[i].v || (q[i].chk_ab && aab !== q[i].ab)) begin
               failures = failures + 1;
               $display("FAIL %s cyc=%0d got={ul,lo,st,H3,H4,H5}=%h ab=%h required=%h ab=%h",
                        q[i].nm, cyc, av, aab, q[i].v, q[i].chk_ab ? q[i].ab : aab);
            end
            q.delete(i);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic press(input int d, input logic [7:0] ab);
      if (d == 0) begin A = ab[7:4]; B = ab[3:0]; enter = 1'b1; end
      else        begin A2 = ab[7:4]; B2 = ab[3:0]; enter2 = 1'b1; end
      tick(1);
      if (d == 0) enter = 1'b0; else enter2 = 1'b0;
      tick(1);
   endtask

   task automatic seq3(input string nm, input logic [7:0] p0, input logic [7:0] p1,
                       input logic [7:0] p2, input logic ok, input logic [3:0] fc);
      exp_at(1, 0, {nm, "_s1"}, 1'b0, 1'b0, 4'd1, fc, G_E);
      press(0, p0);
      exp_at(1, 0, {nm, "_s2"}, 1'b0, 1'b0, 4'd2, fc, G_E);
      press(0, p1);
      exp_at(1, 0, {nm, "_verdict"}, 1'b0, 1'b0, 4'd3, fc, G_C);
      if (ok)            exp_at(2, 0, {nm, "_open"},  1'b1, 1'b0, 4'd0, 4'd0, G_O);
      else if (fc == 2)  exp_at(2, 0, {nm, "_lock"},  1'b0, 1'b1, 4'd0, 4'd3, G_L);
      else               exp_at(2, 0, {nm, "_retry"}, 1'b0, 1'b0, 4'd0, 4'(fc + 1), G_E);
      press(0, p2);
   endtask

   task automatic relock(input string nm);
      exp_at(1, 0, nm, 1'b0, 1'b0, 4'd0, 4'd0, G_E);
      press(0, 8'h00);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      tick(2);
      exp_at(0, 0, "reset_d0", 1'b0, 1'b0, 4'd0, 4'd0, G_E);
      exp_at(0, 1, "reset_d1", 1'b0, 1'b0, 4'd0, 4'd0, G_E);
      tick(1);
      reset = 1'b1;
      tick(1);

      // digit displays, with A/B wiggling alone never moving the state
      for (int i = 0; i < 16; i++) begin
         A = 4'(i);
         B = 4'(15 - i);
         exp_ab("seg_ab", 4'(i), 4'(15 - i));
         tick(1);
      end

      seq3("ok1", 8'h28, 8'h19, 8'h96, 1'b1, 4'd0);
      tick(2);
      exp_at(0, 0, "open_hold", 1'b1, 1'b0, 4'd0, 4'd0, G_O);
      tick(1);
      relock("relock1");
      seq3("ok2", 8'h28, 8'h19, 8'h96, 1'b1, 4'd0);
      relock("relock2");

      seq3("bad1", 8'h28, 8'h18, 8'h96, 1'b0, 4'd0);

      // held enter counts once; finishing correctly clears fail_cnt
      exp_at(1, 0, "hold_s1", 1'b0, 1'b0, 4'd1, 4'd1, G_E);
      exp_at(20, 0, "hold_end", 1'b0, 1'b0, 4'd1, 4'd1, G_E);
      A = 4'h2; B = 4'h8; enter = 1'b1;
      tick(20);
      enter = 1'b0;
      tick(1);
      exp_at(1, 0, "hold_s2", 1'b0, 1'b0, 4'd2, 4'd1, G_E);
      press(0, 8'h19);
      exp_at(1, 0, "hold_verdict", 1'b0, 1'b0, 4'd3, 4'd1, G_C);
      exp_at(2, 0, "hold_open", 1'b1, 1'b0, 4'd0, 4'd0, G_O);
      press(0, 8'h96);
      relock("relock3");

      // lockout: entered 2 cycles after last press, lasts exactly 10 cycles
      seq3("w1", 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
      seq3("w2", 8'h28, 8'h19, 8'h97, 1'b0, 4'd1);
      seq3("w3", 8'h11, 8'h19, 8'h96, 1'b0, 4'd2);
      exp_at(9,  0, "lock_last", 1'b0, 1'b1, 4'd0, 4'd3, G_L);
      exp_at(10, 0, "lock_exit", 1'b0, 1'b0, 4'd0, 4'd0, G_E);
      exp_at(1, 0, "lock_press1", 1'b0, 1'b1, 4'd0, 4'd3, G_L);
      press(0, 8'h28);
      exp_at(1, 0, "lock_press2", 1'b0, 1'b1, 4'd0, 4'd3, G_L);
      press(0, 8'h28);
      tick(8);
      seq3("after_lock", 8'h28, 8'h19, 8'h96, 1'b1, 4'd0);
      relock("relock4");

      // asynchronous reset mid-attempt, checked before any further clock edge
      seq3("bad2", 8'h27, 8'h19, 8'h96, 1'b0, 4'd0);
      exp_at(1, 0, "arst_s1", 1'b0, 1'b0, 4'd1, 4'd1, G_E);
      press(0, 8'h28);
      exp_at(1, 0, "arst_s2", 1'b0, 1'b0, 4'd2, 4'd1, G_E);
      press(0, 8'h19);
      #1;
      exp_at(0, 0, "arst_seq", 1'b0, 1'b0, 4'd0, 4'd0, G_E);
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(1);

      // asynchronous reset mid-lockout
      seq3("x1", 8'h00, 8'h00, 8'h00, 1'b0, 4'd0);
      seq3("x2", 8'h00, 8'h00, 8'h00, 1'b0, 4'd1);
      seq3("x3", 8'h00, 8'h00, 8'h00, 1'b0, 4'd2);
      exp_at(2, 0, "pre_arst", 1'b0, 1'b1, 4'd0, 4'd3, G_L);
      tick(3);
      #1;
      exp_at(0, 0, "arst_lock", 1'b0, 1'b0, 4'd0, 4'd0, G_E);
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(1);
      exp_at(0, 0, "post_arst", 1'b0, 1'b0, 4'd0, 4'd0, G_E);
      tick(1);

      // single-step variant
      exp_at(1, 1, "n1_bad_verdict", 1'b0, 1'b0, 4'd1, 4'd0, G_C);
      exp_at(2, 1, "n1_bad_retry",   1'b0, 1'b0, 4'd0, 4'd1, G_E);
      press(1, 8'h5A);
      exp_at(1, 1, "n1_ok_verdict",  1'b0, 1'b0, 4'd1, 4'd1, G_C);
      exp_at(2, 1, "n1_open",        1'b1, 1'b0, 4'd0, 4'd0, G_O);
      press(1, 8'hA5);
      tick(2);

      for (int k = 0; k < 50 && q.size() > 0; k++) tick(1);
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
